instruction_issuer: RTL and testbench

//  Front end that feeds the processor datapath: holds a small program memory, fetches 32-bit

---
 rtl/processor_defs.sv | 36 +++
 rtl/instr_mem.sv | 36 +++
 rtl/instruction_issuer.sv | 160 ++++++++++++++++
 tb/tb_instruction_issuer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/processor_defs.sv
// Shared definitions for the instruction issuer and the processor datapath.
// Holds opcode constants, the fixed 32-bit instruction field layout and the
// issuer FSM state encoding. No ports.
package processor_defs;

    localparam int INSTR_WORD_W = 32;

    // Opcode values carried in bits [6:0] of every instruction word
    localparam logic [6:0] OP_NONE  = 7'h00;
    localparam logic [6:0] OP_STORE = 7'h01;
    localparam logic [6:0] OP_ADD   = 7'h02;
    localparam logic [6:0] OP_SUB   = 7'h03;
    localparam logic [6:0] OP_HALT  = 7'h7F;

    // Field positions inside the instruction word
    localparam int OP_LSB  = 0;
    localparam int OP_W    = 7;
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int REG_W   = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_HALT   = 3'd4
    } issuer_state_e;

    // True for opcodes that are handed to the datapath
    function automatic logic op_is_issued(input logic [6:0] op);
        return (op == OP_STORE) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/instr_mem.sv
// Program memory for the instruction issuer.
// 2**ADDR_W words of DATA_W bits, synchronous write, registered read
// (data for raddr appears the cycle after it is presented). Contents are not
// reset.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data, registered
module instr_mem #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/instruction_issuer.sv
// Instruction issuer: fetches words from a small program memory, decodes
// them and hands STORE/ADD/SUB instructions to the datapath over a
// valid/ready handshake, one instruction in flight at a time. NOPs are
// skipped, HALT or an undefined opcode stops execution.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   prog_we/addr/data     program load port, honoured only when idle or halted
//   start                 begin execution at pc=0 (idle or halted only)
//   issue_ready           datapath accepts the presented instruction
//   issue_valid           op_code/rs1/rs2/rd valid
//   op_code/rs1/rs2/rd    decoded instruction fields
//   pc                    address of the instruction held/presented
//   busy, halted          FSM status
//   illegal               sticky undefined-opcode flag, cleared by start
//
// state  | meaning
// IDLE   | after reset, waiting for start; program loads allowed
// FETCH  | memory read of word at pc in flight
// DECODE | word available, fields registered, opcode dispatched
// ISSUE  | instruction presented, waiting for issue_ready
// HALT   | stopped by HALT or illegal opcode; loads and restart allowed
module instruction_issuer
    import processor_defs::*;
#(
    parameter int PC_W    = 5,
    // Field layout is fixed, so only a 32-bit word is meaningful
    parameter int INSTR_W = INSTR_WORD_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               start,
    input  logic               issue_ready,
    output logic               issue_valid,
    output logic [6:0]         op_code,
    output logic [4:0]         rs1,
    output logic [4:0]         rs2,
    output logic [4:0]         rd,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               halted,
    output logic               illegal
);

    issuer_state_e state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [REG_W-1:0] rs1_q, rs1_d;
    logic [REG_W-1:0] rs2_q, rs2_d;
    logic [REG_W-1:0] rd_q, rd_d;
    logic             illegal_q, illegal_d;

    logic               mem_we;
    logic [INSTR_W-1:0] instr_word;
    logic [OP_W-1:0]    word_op;
    logic               unused_word_bits;

    // Loads while running are dropped so the program cannot change under
    // the instruction being fetched.
    assign mem_we = prog_we && ((state_q == ST_IDLE) || (state_q == ST_HALT));

    instr_mem #(
        .ADDR_W (PC_W),
        .DATA_W (INSTR_W)
    ) u_instr_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_q),
        .rdata (instr_word)
    );

    assign word_op          = instr_word[OP_LSB +: OP_W];
    assign unused_word_bits = ^{instr_word[INSTR_W-1:RS2_LSB+REG_W],
                                instr_word[RS1_LSB-1:RD_LSB+REG_W]};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        op_d      = op_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        illegal_d = illegal_q;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    pc_d      = '0;
                    illegal_d = 1'b0;
                end
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                op_d  = word_op;
                rs1_d = instr_word[RS1_LSB +: REG_W];
                rs2_d = instr_word[RS2_LSB +: REG_W];
                rd_d  = instr_word[RD_LSB +: REG_W];
                if (word_op == OP_NONE) begin
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_FETCH;
                end else if (word_op == OP_HALT) begin
                    state_d = ST_HALT;
                end else if (op_is_issued(word_op)) begin
                    state_d = ST_ISSUE;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_ISSUE: begin
                if (issue_ready) begin
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            op_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            op_q      <= op_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            illegal_q <= illegal_d;
        end
    end

    assign issue_valid = (state_q == ST_ISSUE);
    assign busy        = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                         (state_q == ST_ISSUE);
    assign halted      = (state_q == ST_HALT);
    assign op_code     = op_q;
    assign rs1         = rs1_q;
    assign rs2         = rs2_q;
    assign rd          = rd_q;
    assign pc          = pc_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_instruction_issuer.sv
// Self-checking bench for instruction_issuer: directed scenarios with literal
// expectations plus a randomized phase, all outputs compared every cycle
// against an instruction-level model.
module tb_instruction_issuer;

    localparam int PC_W  = 5;
    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        prog_we = 1'b0;
    logic [PC_W-1:0] prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic        start = 1'b0;
    logic        issue_ready = 1'b0;
    logic        issue_valid;
    logic [6:0]  op_code;
    logic [4:0]  rs1, rs2, rd;
    logic [PC_W-1:0] pc;
    logic        busy, halted, illegal;

    instruction_issuer #(.PC_W(PC_W), .INSTR_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .start       (start),
        .issue_ready (issue_ready),
        .issue_valid (issue_valid),
        .op_code     (op_code),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    // ---------------- instruction-level reference model ----------------
    // mode: 0 idle, 1 running, 2 halted. While running and not presenting,
    // cd counts the edges until the word at m_pc has been fetched and decoded.
    logic [31:0] m_mem [DEPTH];
    int   m_mode = 0;
    int   m_pc   = 0;
    int   m_cd   = 0;
    bit   m_pres = 0;
    bit   m_ill  = 0;
    logic [31:0] m_word = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_pc = 0; m_cd = 0; m_pres = 0; m_ill = 0; m_word = '0;
        end else if (m_mode != 1) begin
            if (prog_we) m_mem[prog_addr] = prog_data;
            if (start) begin
                m_mode = 1; m_pc = 0; m_ill = 0; m_cd = 2; m_pres = 0;
            end
        end else if (m_pres) begin
            if (issue_ready) begin
                m_pres = 0; m_pc = (m_pc + 1) % DEPTH; m_cd = 2;
            end
        end else begin
            m_cd--;
            if (m_cd == 0) begin
                m_word = m_mem[m_pc];
                case (m_word[6:0])
                    7'h00: begin m_pc = (m_pc + 1) % DEPTH; m_cd = 2; end
                    7'h01, 7'h02, 7'h03: m_pres = 1;
                    7'h7F: m_mode = 2;
                    default: begin m_ill = 1; m_mode = 2; end
                endcase
            end
        end
    end

    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("issue_valid", issue_valid, m_pres);
            chk("busy", busy, m_mode == 1);
            chk("halted", halted, m_mode == 2);
            chk("illegal", illegal, m_ill);
            chk("pc", pc, m_pc);
            if (m_pres) begin
                chk("op_code", op_code, m_word[6:0]);
                chk("rd", rd, m_word[11:7]);
                chk("rs1", rs1, m_word[19:15]);
                chk("rs2", rs2, m_word[24:20]);
            end
        end
    end

    int n_acc = 0;
    always @(posedge clk) if (!reset && issue_valid && issue_ready) n_acc++;

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input int rd_i, input int rs1_i, input int rs2_i);
        logic [4:0] a = rd_i[4:0];
        logic [4:0] b = rs1_i[4:0];
        logic [4:0] c = rs2_i[4:0];
        return {7'b0, c, b, 3'b0, a, op};
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 9);
        logic [6:0] op;
        case (k)
            0, 1: op = 7'h00;
            2, 3: op = 7'h01;
            4:    op = 7'h02;
            5:    op = 7'h03;
            6:    op = 7'h7F;
            default: op = 7'h04 + 7'($urandom_range(0, 120));
        endcase
        w[6:0] = op;
        return w;
    endfunction

    task automatic write_word(input int a, input logic [31:0] w);
        prog_we = 1'b1; prog_addr = a[PC_W-1:0]; prog_data = w;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_valid(input int maxc, output int n, output bit ok);
        n = 0; ok = 0;
        while (n < maxc) begin
            @(negedge clk);
            n++;
            if (issue_valid) begin ok = 1; break; end
        end
    endtask

    task automatic wait_halted(input int maxc, output bit ok);
        int n = 0;
        ok = 0;
        while (n < maxc) begin
            @(negedge clk);
            n++;
            if (halted) begin ok = 1; break; end
        end
    endtask

    initial begin
        int  n;
        bit  ok;
        int  acc0;
        do_reset();
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_pc", pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_op_code", op_code, 0);
        chk("rst_rd", rd, 0);
        cmp_en = 1;

        for (int i = 0; i < DEPTH; i++) write_word(i, mk(7'h7F, 0, 0, 0));

        // 1: ADD then HALT, ready held high; valid appears in the third cycle after start
        write_word(0, mk(7'h02, 10, 2, 3));
        write_word(1, mk(7'h7F, 0, 0, 0));
        issue_ready = 1'b1;
        acc0 = n_acc;
        pulse_start();
        wait_valid(10, n, ok);
        chk("t1_valid_seen", ok, 1);
        chk("t1_latency", n, 3);
        chk("t1_op", op_code, 7'h02);
        chk("t1_rs1", rs1, 2);
        chk("t1_rs2", rs2, 3);
        chk("t1_rd", rd, 10);
        chk("t1_pc", pc, 0);
        wait_halted(10, ok);
        chk("t1_halted", ok, 1);
        chk("t1_pc_halt", pc, 1);
        chk("t1_issues", n_acc - acc0, 1);

        // 2: datapath stalls for 5 cycles
        issue_ready = 1'b0;
        pulse_start();
        wait_valid(10, n, ok);
        chk("t2_valid_seen", ok, 1);
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", issue_valid, 1);
            chk("t2_hold_op", op_code, 7'h02);
            chk("t2_hold_rd", rd, 10);
            chk("t2_hold_pc", pc, 0);
            @(negedge clk);
        end
        issue_ready = 1'b1;
        tick();
        chk("t2_accepted", issue_valid, 0);
        chk("t2_pc_after", pc, 1);
        wait_halted(10, ok);
        chk("t2_halted", ok, 1);

        // 3: leading NOP is skipped
        write_word(0, mk(7'h00, 0, 0, 0));
        write_word(1, mk(7'h03, 14, 4, 5));
        write_word(2, mk(7'h7F, 0, 0, 0));
        acc0 = n_acc;
        pulse_start();
        wait_valid(12, n, ok);
        chk("t3_valid_seen", ok, 1);
        chk("t3_pc", pc, 1);
        chk("t3_op", op_code, 7'h03);
        chk("t3_rd", rd, 14);
        chk("t3_rs1", rs1, 4);
        chk("t3_rs2", rs2, 5);
        wait_halted(10, ok);
        chk("t3_issues", n_acc - acc0, 1);

        // 4: undefined opcode at pc 2
        write_word(0, mk(7'h02, 1, 1, 1));
        write_word(1, mk(7'h03, 2, 2, 2));
        write_word(2, mk(7'h05, 3, 3, 3));
        acc0 = n_acc;
        pulse_start();
        wait_halted(20, ok);
        chk("t4_halted", ok, 1);
        chk("t4_illegal", illegal, 1);
        chk("t4_pc", pc, 2);
        chk("t4_issues", n_acc - acc0, 2);
        pulse_start();
        @(negedge clk);
        chk("t4_illegal_cleared", illegal, 0);
        chk("t4_busy", busy, 1);
        wait_halted(20, ok);

        // 5: no HALT anywhere, pc wraps
        for (int i = 0; i < DEPTH; i++) write_word(i, mk(7'h01, i, 0, 0));
        pulse_start();
        for (int k = 0; k < DEPTH + 2; k++) begin
            wait_valid(10, n, ok);
            chk("t5_valid_seen", ok, 1);
            chk("t5_pc", pc, k % DEPTH);
            chk("t5_rd", rd, k % DEPTH);
            if (k > 0) chk("t5_spacing", n, 3);
        end

        // 6: reset in the middle of a stalled handshake
        issue_ready = 1'b0;
        wait_valid(10, n, ok);
        tick();
        chk("t6_still_valid", issue_valid, 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", issue_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_pc", pc, 0);
        tick();
        reset = 1'b0;
        tick();

        // 6b: a load while busy is dropped
        for (int i = 0; i < 5; i++) write_word(i, mk(7'h00, 0, 0, 0));
        write_word(5, mk(7'h02, 7, 1, 1));
        write_word(6, mk(7'h7F, 0, 0, 0));
        issue_ready = 1'b1;
        pulse_start();
        write_word(5, mk(7'h7F, 0, 0, 0));
        wait_valid(30, n, ok);
        chk("t6b_valid_seen", ok, 1);
        chk("t6b_pc", pc, 5);
        chk("t6b_op", op_code, 7'h02);
        chk("t6b_rd", rd, 7);
        wait_halted(10, ok);
        chk("t6b_halted", ok, 1);

        // start together with a write to address 0: fetch sees the new word
        write_word(1, mk(7'h7F, 0, 0, 0));
        prog_we = 1'b1; prog_addr = '0; prog_data = mk(7'h01, 9, 8, 6);
        start = 1'b1;
        tick();
        prog_we = 1'b0; start = 1'b0;
        wait_valid(10, n, ok);
        chk("t7_valid_seen", ok, 1);
        chk("t7_op", op_code, 7'h01);
        chk("t7_rd", rd, 9);
        wait_halted(10, ok);

        // randomized phase, model carries all checking
        for (int i = 0; i < DEPTH; i++) write_word(i, rand_word());
        for (int c = 0; c < 3000; c++) begin
            issue_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1; prog_we = 1'b0; start = 1'b0;
            end else begin
                reset = 1'b0;
                prog_we = ($urandom_range(0, 3) == 0);
                prog_addr = PC_W'($urandom_range(0, DEPTH - 1));
                prog_data = rand_word();
                start = ($urandom_range(0, 19) == 0);
            end
            tick();
        end
        reset = 1'b0; prog_we = 1'b0; start = 1'b0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
